// File: rtl/control_mvm.sv
`default_nettype none
// ============================================================================
// Module   : control_mvm
// Purpose  : Sequencer for an M x N matrix-vector multiplier. Loads W then X,
//            runs N MAC cycles per row and presents each row result over a
//            valid/ready handshake. Optional macro CONTROL_MVM_WEIGHT_REUSE_EN
//            adds reuse_w to keep W memory across passes.
// Revision : 1.0 - initial release
// ============================================================================
module control_mvm #(
  parameter int M = 3,
  parameter int N = 3,
  localparam int AW_W = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int AW_X = (N > 1) ? $clog2(N) : 1,
  localparam int RW   = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            input_valid,
  input  logic            output_ready,
`ifdef CONTROL_MVM_WEIGHT_REUSE_EN
  input  logic            reuse_w,
`endif
  output logic [AW_X-1:0] addr_x,
  output logic            wr_en_x,
  output logic [AW_W-1:0] addr_w,
  output logic            wr_en_w,
  output logic            clear_acc,
  output logic            en_acc,
  output logic            input_ready,
  output logic            output_valid,
  output logic [RW-1:0]   out_row,
  output logic            out_last
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_X = 3'd2,
    S_MULT   = 3'd3,
    S_SEND   = 3'd4
  } state_t;

  localparam logic [AW_W-1:0] W_LAST = AW_W'(M * N - 1);
  localparam logic [AW_X-1:0] X_LAST = AW_X'(N - 1);
  localparam logic [RW-1:0]   R_LAST = RW'(M - 1);

  state_t          state;
  logic [AW_W-1:0] w_cnt;
  logic [AW_X-1:0] x_cnt;
  logic [RW-1:0]   row_cnt;
  logic            reuse_sel;

`ifdef CONTROL_MVM_WEIGHT_REUSE_EN
  assign reuse_sel = reuse_w;
`else
  assign reuse_sel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RST;
      w_cnt   <= '0;
      x_cnt   <= '0;
      row_cnt <= '0;
    end else begin
      case (state)
        S_RST: state <= S_LOAD_W;

        S_LOAD_W: begin
          if (input_valid) begin
            if (w_cnt == W_LAST) begin
              w_cnt <= '0;
              state <= S_LOAD_X;
            end else begin
              w_cnt <= w_cnt + AW_W'(1);
            end
          end
        end

        S_LOAD_X: begin
          if (input_valid) begin
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              state <= S_MULT;
            end else begin
              x_cnt <= x_cnt + AW_X'(1);
            end
          end
        end

        // w_cnt keeps running across rows so each row starts at row_cnt*N.
        S_MULT: begin
          w_cnt <= w_cnt + AW_W'(1);
          if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            state <= S_SEND;
          end else begin
            x_cnt <= x_cnt + AW_X'(1);
          end
        end

        S_SEND: begin
          if (output_ready) begin
            if (row_cnt == R_LAST) begin
              row_cnt <= '0;
              w_cnt   <= '0;
              state   <= reuse_sel ? S_LOAD_X : S_LOAD_W;
            end else begin
              row_cnt <= row_cnt + RW'(1);
              state   <= S_MULT;
            end
          end
        end

        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    addr_x       = '0;
    wr_en_x      = 1'b0;
    addr_w       = '0;
    wr_en_w      = 1'b0;
    clear_acc    = 1'b0;
    en_acc       = 1'b0;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    out_row      = '0;
    out_last     = 1'b0;
    case (state)
      S_RST: clear_acc = 1'b1;
      S_LOAD_W: begin
        input_ready = 1'b1;
        addr_w      = w_cnt;
        wr_en_w     = input_valid;
      end
      S_LOAD_X: begin
        input_ready = 1'b1;
        addr_x      = x_cnt;
        wr_en_x     = input_valid;
      end
      S_MULT: begin
        en_acc = 1'b1;
        addr_w = w_cnt;
        addr_x = x_cnt;
      end
      S_SEND: begin
        output_valid = 1'b1;
        out_row      = row_cnt;
        out_last     = (row_cnt == R_LAST);
        clear_acc    = output_ready;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_mvm.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_mvm
// Purpose  : Directed bench for control_mvm (M=3, N=3) with a behavioural
//            W/X memory and accumulator driven by the controller outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_mvm;

  localparam int M = 3;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       input_valid;
  logic       output_ready;
  logic       reuse_w;
  logic [7:0] data_in;
  logic [3:0] addr_w;
  logic [1:0] addr_x;
  logic [1:0] out_row;
  logic       wr_en_w, wr_en_x, clear_acc, en_acc, input_ready, output_valid, out_last;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int nw = 0;
  int nx = 0;
  int acc = 0;
  int wmem [M*N];
  int xmem [N];
  int w_vals [M*N];
  int x_vals [N];

  control_mvm #(.M(M), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_valid  (input_valid),
    .output_ready (output_ready),
`ifdef CONTROL_MVM_WEIGHT_REUSE_EN
    .reuse_w      (reuse_w),
`endif
    .addr_x       (addr_x),
    .wr_en_x      (wr_en_x),
    .addr_w       (addr_w),
    .wr_en_w      (wr_en_w),
    .clear_acc    (clear_acc),
    .en_acc       (en_acc),
    .input_ready  (input_ready),
    .output_valid (output_valid),
    .out_row      (out_row),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  // Memory/accumulator model: only reacts to the controller's strobes.
  always @(posedge clk) begin
    if (wr_en_w) begin wmem[addr_w] <= int'(data_in); nw <= nw + 1; end
    if (wr_en_x) begin xmem[addr_x] <= int'(data_in); nx <= nx + 1; end
    if (clear_acc) acc <= 0;
    else if (en_acc) acc <= acc + wmem[addr_w] * xmem[addr_x];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    cmp_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_val("excl_acc", 32'(en_acc & clear_acc), 0);
      check_val("excl_wr", 32'(en_acc & (wr_en_w | wr_en_x)), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input bit toggle);
    for (int i = 0; i < M*N; i++) begin
      input_valid = 1'b1;
      data_in     = 8'(w_vals[i]);
      #1;
      check_val("load_w_addr", 32'(addr_w), i);
      check_val("load_w_we", 32'(wr_en_w), 1);
      step();
      if (toggle) begin
        input_valid = 1'b0;
        #1;
        check_val("load_w_gap", 32'(wr_en_w), 0);
        step();
      end
    end
    input_valid = 1'b0;
  endtask

  task automatic load_x(input bit toggle);
    for (int i = 0; i < N; i++) begin
      input_valid = 1'b1;
      data_in     = 8'(x_vals[i]);
      #1;
      check_val("load_x_addr", 32'(addr_x), i);
      check_val("load_x_we", 32'(wr_en_x), 1);
      step();
      if (toggle && i != N-1) begin
        input_valid = 1'b0;
        #1;
        check_val("load_x_gap", 32'(wr_en_x), 0);
        step();
      end
    end
    input_valid = 1'b0;
  endtask

  // Waits for a row, checks it, optionally stalls, then completes the handshake.
  task automatic collect_row(input int exp_val, input int exp_row, input int hold);
    int waits = 0;
    while (!output_valid && waits < 20) begin
      step();
      waits++;
    end
    check_val("row_valid", 32'(output_valid), 1);
    check_val("row_latency", waits, N);
    check_val("row_result", acc, exp_val);
    check_val("row_index", 32'(out_row), exp_row);
    check_val("row_last", 32'(out_last), (exp_row == M-1) ? 1 : 0);
    if (hold > 0) begin
      output_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        step();
        check_val("stall_valid", 32'(output_valid), 1);
        check_val("stall_result", acc, exp_val);
        check_val("stall_en_acc", 32'(en_acc), 0);
        check_val("stall_row", 32'(out_row), exp_row);
      end
      output_ready = 1'b1;
    end
    step();
  endtask

  initial begin
    rst = 1'b1; input_valid = 1'b0; output_ready = 1'b1; reuse_w = 1'b0; data_in = '0;
    for (int i = 0; i < M*N; i++) w_vals[i] = i + 1;
    for (int i = 0; i < N; i++) x_vals[i] = i + 1;
    step(); step();
    check_val("rst_clear_acc", 32'(clear_acc), 1);
    check_val("rst_input_ready", 32'(input_ready), 0);
    check_val("rst_output_valid", 32'(output_valid), 0);
    rst = 1'b0;
    step();
    check_val("loadw_ready", 32'(input_ready), 1);

    // Pass 1: gapped input stream.
    nw = 0; nx = 0;
    load_w(1'b1);
    load_x(1'b1);
    check_val("write_count", nw + nx, 12);
    collect_row(14, 0, 0);
    collect_row(32, 1, 5);
    collect_row(50, 2, 0);

    // Pass 2: reset during the second MAC cycle of row 1.
    check_val("p2_addr_w", 32'(addr_w), 0);
    load_w(1'b0);
    load_x(1'b0);
    collect_row(14, 0, 0);
    step();
    check_val("mid_mult_en", 32'(en_acc), 1);
    rst = 1'b1;
    step();
    check_val("midrst_clear", 32'(clear_acc), 1);
    check_val("midrst_en_acc", 32'(en_acc), 0);
    check_val("midrst_ready", 32'(input_ready), 0);
    rst = 1'b0;
    step();
    check_val("reload_ready", 32'(input_ready), 1);
    check_val("reload_addr_w", 32'(addr_w), 0);

    // Pass 3 then back-to-back pass 4.
    load_w(1'b0);
    load_x(1'b0);
    collect_row(14, 0, 0);
    collect_row(32, 1, 0);
    collect_row(50, 2, 0);
    check_val("b2b_ready", 32'(input_ready), 1);
    check_val("b2b_addr_w", 32'(addr_w), 0);
    for (int i = 0; i < M*N; i++) w_vals[i] = 2 * (i + 1);
    load_w(1'b0);
    load_x(1'b0);
    collect_row(28, 0, 0);
    collect_row(64, 1, 0);
`ifdef CONTROL_MVM_WEIGHT_REUSE_EN
    reuse_w = 1'b1;
`endif
    collect_row(100, 2, 0);

`ifdef CONTROL_MVM_WEIGHT_REUSE_EN
    // Weights kept: only X is reloaded.
    reuse_w = 1'b0;
    check_val("reuse_ready", 32'(input_ready), 1);
    check_val("reuse_no_w", 32'(wr_en_w), 0);
    begin
      int nw_snap;
      nw_snap = nw;
      x_vals[0] = 1; x_vals[1] = 0; x_vals[2] = 0;
      for (int i = 0; i < M*N; i++) w_vals[i] = i + 1;
      load_x(1'b0);
      collect_row(2, 0, 0);
      collect_row(8, 1, 0);
      collect_row(14, 2, 0);
      check_val("reuse_w_writes", nw - nw_snap, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
